ir_queue: RTL and testbench

Parametrised instruction register and queue for the multi-cycle/microprogrammed CPU. It buffers up to DEPTH fetched 32-bit MIPS instructions between instruction memory and the control/decode stage using valid/ready handshakes. It presents the head instruction already split into its fields, plus a 32-bit extended immediate. It supports a synchronous flush for branches and jumps.

---
 rtl/ir_queue_if.sv | 33 +++
 rtl/ir_queue.sv | 73 +++++++
 tb/tb_ir_queue.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ir_queue_if.sv
// Handshake and decoded-field bundle between instruction fetch, the queue and decode.
interface ir_queue_if #(
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic             ext_sign;
  logic [5:0]       op_code;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       func;
  logic [15:0]      imm16;
  logic [31:0]      imm_ext;
  logic [25:0]      addr26;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_inst, out_ready, ext_sign,
    input  in_ready, out_valid, op_code, rs, rt, rd, shamt, func,
           imm16, imm_ext, addr26, count
  );

  modport slave (
    input  in_valid, in_inst, out_ready, ext_sign,
    output in_ready, out_valid, op_code, rs, rt, rd, shamt, func,
           imm16, imm_ext, addr26, count
  );
endinterface

// File: rtl/ir_queue.sv
// Instruction register queue: circular buffer of fetched MIPS words with the
// head entry presented pre-split into its fields plus an extended immediate.
module ir_queue #(
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH + 1),
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  ir_queue_if.slave     q
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic [31:0]      head;

  // No bypass: a full queue refuses input even when the head is being popped.
  assign q.in_ready  = (count_q != CNT_W'(DEPTH));
  assign q.out_valid = (count_q != '0);
  assign push        = q.in_valid && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= q.in_inst;
  end

  assign head      = q.out_valid ? mem_q[rd_ptr_q] : NOP_INST;
  assign q.op_code = head[31:26];
  assign q.rs      = head[25:21];
  assign q.rt      = head[20:16];
  assign q.rd      = head[15:11];
  assign q.shamt   = head[10:6];
  assign q.func    = head[5:0];
  assign q.imm16   = head[15:0];
  assign q.imm_ext = {{16{head[15] & q.ext_sign}}, head[15:0]};
  assign q.addr26  = head[25:0];
  assign q.count   = count_q;
endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: queue-based reference model compared every
// cycle, plus hand-computed expectations for the documented scenarios.
module tb_ir_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int checks = 0;
  int errors = 0;

  ir_queue_if #(.CNT_W(CNT_W)) bus ();

  ir_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .NOP_INST(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .q     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held instructions.
  logic [31:0] mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      bit can_push, can_pop;
      can_push = bus.in_valid && (mq.size() < DEPTH);
      can_pop  = bus.out_ready && (mq.size() > 0);
      if (can_pop) void'(mq.pop_front());
      if (can_push) mq.push_back(bus.in_inst);
    end
  end

  always @(negedge clk) begin
    logic [31:0] h;
    logic [31:0] ext;
    h = (mq.size() != 0) ? mq[0] : 32'h0;
    ext = bus.ext_sign ? 32'($signed(h[15:0])) : {16'h0, h[15:0]};
    chk("m_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("m_in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk("m_count", 32'(bus.count), 32'(mq.size()));
    chk("m_op_code", 32'(bus.op_code), 32'(h >> 26));
    chk("m_rs", 32'(bus.rs), (h >> 21) % 32);
    chk("m_rt", 32'(bus.rt), (h >> 16) % 32);
    chk("m_rd", 32'(bus.rd), (h >> 11) % 32);
    chk("m_shamt", 32'(bus.shamt), (h >> 6) % 32);
    chk("m_func", 32'(bus.func), h % 64);
    chk("m_imm16", 32'(bus.imm16), h % 65536);
    chk("m_imm_ext", bus.imm_ext, ext);
    chk("m_addr26", 32'(bus.addr26), h % (1 << 26));
  end

  task automatic drive(input logic v, input logic [31:0] inst, input logic rdy);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.out_ready = 1'b0;
    bus.ext_sign  = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_imm_ext", bus.imm_ext, 32'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // lw $2,4($1)
    bus.ext_sign = 1'b1;
    drive(1'b1, 32'h8C22_0004, 1'b0);
    chk("lw_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lw_op_code", 32'(bus.op_code), 32'h23);
    chk("lw_rs", 32'(bus.rs), 32'd1);
    chk("lw_rt", 32'(bus.rt), 32'd2);
    chk("lw_imm16", 32'(bus.imm16), 32'h4);
    chk("lw_imm_ext", bus.imm_ext, 32'h4);
    chk("lw_count", 32'(bus.count), 32'd1);
    drive(1'b0, 32'h0, 1'b1);

    // ext_sign acts combinationally on the head
    drive(1'b1, 32'h2021_FFFF, 1'b0);
    bus.ext_sign = 1'b1;
    #1;
    chk("sext_imm", bus.imm_ext, 32'hFFFF_FFFF);
    bus.ext_sign = 1'b0;
    #1;
    chk("zext_imm", bus.imm_ext, 32'h0000_FFFF);
    drive(1'b0, 32'h0, 1'b1);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, 32'(i), 1'b0);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_count", 32'(bus.count), 32'd4);
    drive(1'b1, 32'h5, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd4);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_func", 32'(bus.func), 32'(i));
      drive(1'b0, 32'h0, 1'b1);
    end
    chk("empty_out_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_op_code", 32'(bus.op_code), 32'd0);
    chk("empty_func", 32'(bus.func), 32'd0);
    chk("empty_addr26", 32'(bus.addr26), 32'd0);

    // Empty boundary: push with out_ready leaves one entry
    drive(1'b1, 32'h0000_0077, 1'b1);
    chk("empty_pushpop_count", 32'(bus.count), 32'd1);

    // Streaming: one push and one pop every cycle across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(101 + i), 1'b1);
      chk("stream_count", 32'(bus.count), 32'd1);
    end
    chk("stream_head", 32'(bus.imm16), 32'd110);
    drive(1'b0, 32'h0, 1'b1);

    // Flush wins over a simultaneous push
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h0800_0010, 1'b0);
    flush = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_addr26", 32'(bus.addr26), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bus.ext_sign = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 31) == 0);
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'h0, 1'b1);

    // Asynchronous reset between edges
    drive(1'b1, 32'h1111_1111, 1'b0);
    drive(1'b1, 32'h2222_2222, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_arst_count", 32'(bus.count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
